// File: rtl/medyan_pencere_planlayici.sv
// Column-stream scheduler feeding a 3x3 median array, with a credit-limited output FIFO.
// Optional stall counter port durma_sayisi_o: define PLANLAYICI_DURMA_SAYACI_EN.

module medyan_pencere_planlayici #(
    parameter int FIFO_DERINLIK = 16,
    parameter int BOYUT_BIT     = 10
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 baslat_i,
    input  logic [BOYUT_BIT-1:0] genislik_i,
    input  logic [BOYUT_BIT-1:0] yukseklik_i,
    input  logic                 sutun_gecerli_i,
    input  logic [23:0]          sutun_i,
    output logic                 sutun_hazir_o,
    output logic                 medyan_etkin_o,
    output logic [71:0]          medyan_resim_o,
    input  logic                 medyan_etkin_i,
    input  logic [7:0]           medyan_pixel_i,
    output logic                 cikis_gecerli_o,
    output logic [7:0]           cikis_pixel_o,
    input  logic                 cikis_hazir_i,
    output logic                 cikis_son_o,
    output logic                 mesgul_o,
    output logic                 bitti_o
`ifdef PLANLAYICI_DURMA_SAYACI_EN
    ,
    output logic [15:0]          durma_sayisi_o
`endif
);

    localparam int AW = $clog2(FIFO_DERINLIK);
    localparam int KW = AW + 1;
    localparam int SW = 2 * BOYUT_BIT;
    localparam logic [3:0]    UCUS_SINIR  = 4'd10;
    localparam logic [KW-1:0] KREDI_SINIR = KW'(FIFO_DERINLIK);

    typedef enum logic [1:0] {BOSTA, DOLDUR, AKIS, BOSALT} durum_t;
    durum_t durum, durum_sonraki;

    logic [BOYUT_BIT-1:0] genislik, yukseklik, sayac, serit;
    logic [71:0]          pencere;
    logic                 etkin;
    logic [3:0]           ucus;
    logic [KW-1:0]        kredi, doluluk;
    logic [AW-1:0]        yaz_ptr, oku_ptr;
    logic [7:0]           bellek [FIFO_DERINLIK];
    logic [SW-1:0]        cikis_sayac, toplam;

    logic baslat_kabul, akis_hazir, yeni_pencere, doldur_kabul;
    logic donus, cekme, serit_sonu, son_serit;

    assign baslat_kabul = baslat_i && (durum == BOSTA);
    assign akis_hazir   = (ucus < UCUS_SINIR) && (kredi < KREDI_SINIR);
    assign yeni_pencere = (durum == AKIS) && sutun_gecerli_i && akis_hazir;
    assign doldur_kabul = (durum == DOLDUR) && sutun_gecerli_i;
    // A returning median is only accepted against an outstanding window, so the
    // credit bound guarantees a free FIFO slot for every push.
    assign donus        = medyan_etkin_i && (durum != BOSTA) && (ucus != '0);
    assign cekme        = cikis_gecerli_o && cikis_hazir_i;
    assign serit_sonu   = (sayac == genislik - BOYUT_BIT'(3));
    assign son_serit    = (serit == yukseklik - BOYUT_BIT'(1));

    always_comb begin
        durum_sonraki = durum;
        sutun_hazir_o = 1'b0;
        bitti_o       = 1'b0;
        case (durum)
            BOSTA: begin
                if (baslat_i) durum_sonraki = DOLDUR;
            end
            DOLDUR: begin
                sutun_hazir_o = 1'b1;
                if (sutun_gecerli_i && (sayac == BOYUT_BIT'(1))) durum_sonraki = AKIS;
            end
            AKIS: begin
                sutun_hazir_o = akis_hazir;
                if (yeni_pencere && serit_sonu) durum_sonraki = son_serit ? BOSALT : DOLDUR;
            end
            BOSALT: begin
                if (kredi == '0) begin
                    bitti_o       = 1'b1;
                    durum_sonraki = BOSTA;
                end
            end
            default: durum_sonraki = BOSTA;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            durum     <= BOSTA;
            genislik  <= '0;
            yukseklik <= '0;
            sayac     <= '0;
            serit     <= '0;
            toplam    <= '0;
            pencere   <= '0;
            etkin     <= 1'b0;
        end else begin
            durum <= durum_sonraki;
            etkin <= yeni_pencere;
            if (baslat_kabul) begin
                genislik  <= genislik_i;
                yukseklik <= yukseklik_i;
                sayac     <= '0;
                serit     <= '0;
                toplam    <= SW'(yukseklik_i) * (SW'(genislik_i) - SW'(2));
            end else if (doldur_kabul) begin
                pencere <= {sutun_i, pencere[71:24]};
                sayac   <= (sayac == BOYUT_BIT'(1)) ? '0 : sayac + BOYUT_BIT'(1);
            end else if (yeni_pencere) begin
                pencere <= {sutun_i, pencere[71:24]};
                if (serit_sonu) begin
                    sayac <= '0;
                    serit <= serit + BOYUT_BIT'(1);
                end else begin
                    sayac <= sayac + BOYUT_BIT'(1);
                end
            end
        end
    end

    // Credit covers both unreturned windows and pixels still waiting in the FIFO.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ucus        <= '0;
            kredi       <= '0;
            doluluk     <= '0;
            yaz_ptr     <= '0;
            oku_ptr     <= '0;
            cikis_sayac <= '0;
        end else begin
            case ({yeni_pencere, donus})
                2'b10:   ucus <= ucus + 4'd1;
                2'b01:   ucus <= ucus - 4'd1;
                default: ucus <= ucus;
            endcase
            case ({yeni_pencere, cekme})
                2'b10:   kredi <= kredi + KW'(1);
                2'b01:   kredi <= kredi - KW'(1);
                default: kredi <= kredi;
            endcase
            case ({donus, cekme})
                2'b10:   doluluk <= doluluk + KW'(1);
                2'b01:   doluluk <= doluluk - KW'(1);
                default: doluluk <= doluluk;
            endcase
            if (donus) yaz_ptr <= yaz_ptr + AW'(1);
            if (cekme) oku_ptr <= oku_ptr + AW'(1);
            if (baslat_kabul)  cikis_sayac <= '0;
            else if (cekme)    cikis_sayac <= cikis_sayac + SW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (donus) bellek[yaz_ptr] <= medyan_pixel_i;
    end

    assign cikis_gecerli_o = (doluluk != '0);
    assign cikis_pixel_o   = cikis_gecerli_o ? bellek[oku_ptr] : '0;
    assign cikis_son_o     = cikis_gecerli_o && (cikis_sayac == toplam - SW'(1));
    assign medyan_etkin_o  = etkin;
    assign medyan_resim_o  = pencere;
    assign mesgul_o        = (durum != BOSTA);

`ifdef PLANLAYICI_DURMA_SAYACI_EN
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            durma_sayisi_o <= '0;
        end else if (baslat_kabul) begin
            durma_sayisi_o <= '0;
        end else if ((durum == AKIS) && sutun_gecerli_i && !sutun_hazir_o && (durma_sayisi_o != '1)) begin
            durma_sayisi_o <= durma_sayisi_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_medyan_pencere_planlayici.sv
// Directed bench for medyan_pencere_planlayici with a behavioural median-array responder.

module tb_medyan_pencere_planlayici;

    logic        clk_i;
    logic        rstn_i;
    logic        baslat_i;
    logic [9:0]  genislik_i, yukseklik_i;
    logic        sutun_gecerli_i;
    logic [23:0] sutun_i;
    logic        sutun_hazir_o;
    logic        medyan_etkin_o;
    logic [71:0] medyan_resim_o;
    logic        medyan_etkin_i;
    logic [7:0]  medyan_pixel_i;
    logic        cikis_gecerli_o;
    logic [7:0]  cikis_pixel_o;
    logic        cikis_hazir_i;
    logic        cikis_son_o;
    logic        mesgul_o;
    logic        bitti_o;
`ifdef PLANLAYICI_DURMA_SAYACI_EN
    logic [15:0] durma_sayisi_o;
`endif

    medyan_pencere_planlayici #(.FIFO_DERINLIK(16), .BOYUT_BIT(10)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .baslat_i(baslat_i),
        .genislik_i(genislik_i), .yukseklik_i(yukseklik_i),
        .sutun_gecerli_i(sutun_gecerli_i), .sutun_i(sutun_i), .sutun_hazir_o(sutun_hazir_o),
        .medyan_etkin_o(medyan_etkin_o), .medyan_resim_o(medyan_resim_o),
        .medyan_etkin_i(medyan_etkin_i), .medyan_pixel_i(medyan_pixel_i),
        .cikis_gecerli_o(cikis_gecerli_o), .cikis_pixel_o(cikis_pixel_o),
        .cikis_hazir_i(cikis_hazir_i), .cikis_son_o(cikis_son_o),
        .mesgul_o(mesgul_o), .bitti_o(bitti_o)
`ifdef PLANLAYICI_DURMA_SAYACI_EN
        , .durma_sayisi_o(durma_sayisi_o)
`endif
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    typedef struct {int due; logic [7:0] val;} yanit_t;

    int          pass_cnt, total_cnt, cyc, lat, cikis_mod;
    int          pencere_say, bitti_say, durma_gozlem;
    logic [23:0] sutun_q[$];
    yanit_t      yanit_q[$];
    logic [7:0]  alinan_q[$];
    logic        son_q[$];
    logic [7:0]  beklenen[$];
    logic [71:0] son_pencere;
    logic        stray;
    logic [7:0]  stray_val;

    function automatic logic [7:0] medyan9(input logic [71:0] p);
        logic [7:0] a[9];
        logic [7:0] t;
        for (int i = 0; i < 9; i++) a[i] = p[8*i +: 8];
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 8 - i; j++)
                if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
        return a[4];
    endfunction

    function automatic logic [85:0] cikislar();
        return {sutun_hazir_o, medyan_etkin_o, medyan_resim_o, cikis_gecerli_o,
                cikis_pixel_o, cikis_son_o, mesgul_o, bitti_o};
    endfunction

    // One cycle: apply stimulus at the falling edge, observe handshakes, advance.
    task automatic adim();
        yanit_t y;
        if (sutun_q.size() > 0) begin sutun_gecerli_i = 1'b1; sutun_i = sutun_q[0]; end
        else begin sutun_gecerli_i = 1'b0; sutun_i = '0; end
        cikis_hazir_i = (cikis_mod == 1) || ((cikis_mod == 2) && (cyc % 2 == 1));
        if (yanit_q.size() > 0 && yanit_q[0].due <= cyc) begin
            medyan_etkin_i = 1'b1; medyan_pixel_i = yanit_q[0].val; void'(yanit_q.pop_front());
        end else if (stray) begin
            medyan_etkin_i = 1'b1; medyan_pixel_i = stray_val; stray = 1'b0;
        end else begin
            medyan_etkin_i = 1'b0; medyan_pixel_i = '0;
        end
        #1;
        if (sutun_gecerli_i && sutun_hazir_o) void'(sutun_q.pop_front());
        if (sutun_gecerli_i && !sutun_hazir_o && mesgul_o) durma_gozlem++;
        if (cikis_gecerli_o && cikis_hazir_i) begin
            alinan_q.push_back(cikis_pixel_o); son_q.push_back(cikis_son_o);
        end
        if (medyan_etkin_o) begin
            pencere_say++; son_pencere = medyan_resim_o;
            y.due = cyc + lat; y.val = medyan9(medyan_resim_o); yanit_q.push_back(y);
        end
        if (bitti_o) bitti_say++;
        @(negedge clk_i);
        cyc++;
    endtask

    task automatic hazirla(input int w, input int h, input int tohum);
        logic [23:0] kolon[64];
        sutun_q.delete(); beklenen.delete(); alinan_q.delete(); son_q.delete(); yanit_q.delete();
        pencere_say = 0; bitti_say = 0; durma_gozlem = 0;
        for (int i = 0; i < w * h; i++) begin
            kolon[i] = {8'(i * 53 + tohum + 200), 8'(i * 91 + tohum + 5), 8'(i * 37 + tohum + 11)};
            sutun_q.push_back(kolon[i]);
        end
        for (int s = 0; s < h; s++)
            for (int j = 0; j < w - 2; j++)
                beklenen.push_back(medyan9({kolon[s*w+j+2], kolon[s*w+j+1], kolon[s*w+j]}));
    endtask

    task automatic baslat(input int w, input int h);
        genislik_i = 10'(w); yukseklik_i = 10'(h); baslat_i = 1'b1;
        adim();
        baslat_i = 1'b0;
    endtask

    task automatic bekle_bitti(input int butce);
        int b0 = bitti_say;
        for (int i = 0; i < butce && bitti_say == b0; i++) adim();
    endtask

    task automatic test_reset();
        #3;
        total_cnt++;
        if (cikislar() !== 86'd0) $display("FAIL reset_outputs: got %h expected 0", cikislar());
        else pass_cnt++;
        baslat_i = 1'b1; sutun_gecerli_i = 1'b1; sutun_i = 24'hFFFFFF;
        medyan_etkin_i = 1'b1; medyan_pixel_i = 8'h55; cikis_hazir_i = 1'b1;
        @(negedge clk_i); @(negedge clk_i);
        total_cnt++;
        if (cikislar() !== 86'd0) $display("FAIL reset_hold: got %h expected 0", cikislar());
        else pass_cnt++;
        baslat_i = 1'b0; sutun_gecerli_i = 1'b0; sutun_i = '0;
        medyan_etkin_i = 1'b0; medyan_pixel_i = '0; cikis_hazir_i = 1'b0;
        rstn_i = 1'b1;
        adim();
        total_cnt++;
        if ({mesgul_o, cikis_gecerli_o} !== 2'b00)
            $display("FAIL post_reset_idle: got %b expected 00", {mesgul_o, cikis_gecerli_o});
        else pass_cnt++;
    endtask

    task automatic test_tek_pencere();
        hazirla(0, 0, 0);
        sutun_q.push_back(24'h030201); sutun_q.push_back(24'h060504); sutun_q.push_back(24'h090807);
        lat = 4; cikis_mod = 1;
        baslat(3, 1);
        total_cnt++;
        if ({mesgul_o, sutun_hazir_o} !== 2'b11)
            $display("FAIL fill_ready: got %b expected 11", {mesgul_o, sutun_hazir_o});
        else pass_cnt++;
        bekle_bitti(100);
        total_cnt++;
        if (pencere_say !== 1) $display("FAIL single_window_count: got %0d expected 1", pencere_say);
        else pass_cnt++;
        total_cnt++;
        if (son_pencere !== 72'h090807060504030201)
            $display("FAIL window_bytes: got %h expected 090807060504030201", son_pencere);
        else pass_cnt++;
        total_cnt++;
        if (alinan_q.size() !== 1) $display("FAIL single_out_count: got %0d expected 1", alinan_q.size());
        else pass_cnt++;
        total_cnt++;
        if (alinan_q.size() > 0 && {alinan_q[0], son_q[0]} !== {8'h05, 1'b1})
            $display("FAIL single_pixel_last: got %h/%b expected 05/1", alinan_q[0], son_q[0]);
        else pass_cnt++;
        total_cnt++;
        if (bitti_say !== 1) $display("FAIL single_done: got %0d expected 1", bitti_say);
        else pass_cnt++;
        total_cnt++;
        if (mesgul_o !== 1'b0) $display("FAIL single_idle: got %b expected 0", mesgul_o);
        else pass_cnt++;
    endtask

    task automatic test_geri_basinc(input int gecikme, input int mod);
        int hata, son_say;
        hazirla(16, 2, gecikme);
        lat = gecikme; cikis_mod = 0;
        baslat(16, 2);
        if (gecikme >= 20) begin
            repeat (30) adim();
            total_cnt++;
            if ({pencere_say, sutun_hazir_o} !== {32'd10, 1'b0})
                $display("FAIL inflight_limit: got %0d/%b expected 10/0", pencere_say, sutun_hazir_o);
            else pass_cnt++;
        end
        repeat (150) adim();
        total_cnt++;
        if ({pencere_say, sutun_hazir_o, cikis_gecerli_o} !== {32'd16, 1'b0, 1'b1})
            $display("FAIL credit_limit: got %0d/%b/%b expected 16/0/1", pencere_say, sutun_hazir_o, cikis_gecerli_o);
        else pass_cnt++;
`ifdef PLANLAYICI_DURMA_SAYACI_EN
        total_cnt++;
        if (durma_sayisi_o !== 16'(durma_gozlem))
            $display("FAIL stall_count: got %0d expected %0d", durma_sayisi_o, durma_gozlem);
        else pass_cnt++;
`endif
        cikis_mod = mod;
        bekle_bitti(600);
        total_cnt++;
        if (alinan_q.size() !== 28) $display("FAIL stream_count: got %0d expected 28", alinan_q.size());
        else pass_cnt++;
        hata = 0; son_say = 0;
        for (int i = 0; i < alinan_q.size() && i < beklenen.size(); i++)
            if (alinan_q[i] !== beklenen[i]) hata++;
        for (int i = 0; i < son_q.size(); i++) if (son_q[i]) son_say++;
        total_cnt++;
        if (hata !== 0) $display("FAIL stream_order: got %0d wrong pixels expected 0", hata);
        else pass_cnt++;
        total_cnt++;
        if (son_say !== 1 || son_q.size() == 0 || son_q[son_q.size()-1] !== 1'b1)
            $display("FAIL stream_last: got %0d flags expected 1 on final pixel", son_say);
        else pass_cnt++;
        total_cnt++;
        if (bitti_say !== 1) $display("FAIL stream_done: got %0d expected 1", bitti_say);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int b0, hata;
        hazirla(16, 2, 21);
        lat = 40; cikis_mod = 1;
        baslat(16, 2);
        for (int i = 0; i < 50 && pencere_say < 5; i++) adim();
        total_cnt++;
        if (pencere_say !== 5) $display("FAIL mid_inflight: got %0d expected 5", pencere_say);
        else pass_cnt++;
        #2 rstn_i = 1'b0;
        #1;
        total_cnt++;
        if (cikislar() !== 86'd0) $display("FAIL async_reset: got %h expected 0", cikislar());
        else pass_cnt++;
        sutun_q.delete(); yanit_q.delete();
        b0 = bitti_say;
        repeat (3) adim();
        total_cnt++;
        if (bitti_say !== b0 || cikislar() !== 86'd0)
            $display("FAIL reset_quiet: got done=%0d out=%h expected done=%0d out=0", bitti_say, cikislar(), b0);
        else pass_cnt++;
        rstn_i = 1'b1;
        hazirla(4, 1, 7);
        lat = 2; cikis_mod = 1;
        baslat(4, 1);
        bekle_bitti(200);
        hata = 0;
        for (int i = 0; i < alinan_q.size() && i < beklenen.size(); i++)
            if (alinan_q[i] !== beklenen[i]) hata++;
        total_cnt++;
        if (alinan_q.size() !== 2 || hata !== 0)
            $display("FAIL clean_frame: got %0d pixels %0d wrong expected 2 pixels 0 wrong", alinan_q.size(), hata);
        else pass_cnt++;
        total_cnt++;
        if (son_q.size() != 2 || {son_q[0], son_q[1]} !== 2'b01 || bitti_say !== 1)
            $display("FAIL clean_frame_end: got last=%b done=%0d expected 01/1",
                     (son_q.size() == 2) ? {son_q[0], son_q[1]} : 2'bxx, bitti_say);
        else pass_cnt++;
    endtask

    task automatic test_yoksay();
        int hata;
        hazirla(5, 1, 3);
        lat = 3; cikis_mod = 1;
        baslat(5, 1);
        repeat (3) adim();
        genislik_i = 10'd10; yukseklik_i = 10'd3; baslat_i = 1'b1;
        adim();
        baslat_i = 1'b0;
        bekle_bitti(200);
        hata = 0;
        for (int i = 0; i < alinan_q.size() && i < beklenen.size(); i++)
            if (alinan_q[i] !== beklenen[i]) hata++;
        total_cnt++;
        if (alinan_q.size() !== 3 || hata !== 0 || bitti_say !== 1)
            $display("FAIL ignored_start: got %0d pixels %0d wrong done=%0d expected 3/0/1", alinan_q.size(), hata, bitti_say);
        else pass_cnt++;
        total_cnt++;
        if (son_q.size() != 3 || son_q[2] !== 1'b1 || son_q[0] !== 1'b0)
            $display("FAIL ignored_start_last: got %0d flags expected last only", son_q.size());
        else pass_cnt++;
        stray = 1'b1; stray_val = 8'hAA;
        adim();
        total_cnt++;
        if ({cikis_gecerli_o, cikis_pixel_o} !== 9'd0)
            $display("FAIL stray_discard: got %b/%h expected 0/00", cikis_gecerli_o, cikis_pixel_o);
        else pass_cnt++;
        hazirla(3, 1, 9);
        baslat(3, 1);
        bekle_bitti(100);
        total_cnt++;
        if (alinan_q.size() !== 1 || bitti_say !== 1 || (alinan_q.size() > 0 && alinan_q[0] !== beklenen[0]))
            $display("FAIL after_stray_frame: got %0d pixels done=%0d expected 1/1", alinan_q.size(), bitti_say);
        else pass_cnt++;
    endtask

    initial begin
        rstn_i = 1'b0; baslat_i = 1'b0; genislik_i = '0; yukseklik_i = '0;
        sutun_gecerli_i = 1'b0; sutun_i = '0; medyan_etkin_i = 1'b0; medyan_pixel_i = '0;
        cikis_hazir_i = 1'b0;
        pass_cnt = 0; total_cnt = 0; cyc = 0; lat = 1; cikis_mod = 0;
        pencere_say = 0; bitti_say = 0; durma_gozlem = 0; stray = 1'b0; stray_val = '0;
        son_pencere = '0;
        test_reset();
        test_tek_pencere();
        test_geri_basinc(40, 1);
        test_geri_basinc(1, 2);
        test_reset_mid();
        test_yoksay();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/medyan_pencere_planlayici.md
MEDYAN_PENCERE_PLANLAYICI -- requirements
Module: medyan_pencere_planlayici

Interface
REQ-001 SHALL have parameter FIFO_DERINLIK, default 16, meaning output FIFO depth in pixels (power of two, >=10).
REQ-002 SHALL have parameter BOYUT_BIT, default 10, meaning width of the image-size inputs.
REQ-003 clk_i  input  1  single clock; all state on rising edge.
REQ-004 rstn_i  input  1  reset, asynchronous, active-low.
REQ-005 baslat_i  input  1  start pulse; sizes are sampled in the same cycle.
REQ-006 genislik_i / yukseklik_i  input  BOYUT_BIT each  columns per strip (>=3) / strip count (>=1).
REQ-007 sutun_gecerli_i, sutun_i[23:0]  input  column valid; 3 vertical pixels, [7:0]=top row.
REQ-008 sutun_hazir_o  output  1  column accepted when high with sutun_gecerli_i.
REQ-009 medyan_etkin_o, medyan_resim_o[71:0]  output  window to median array; byte k = column(k/3), row(k%3); column 0 oldest.
REQ-010 medyan_etkin_i, medyan_pixel_i[7:0]  input  median result strobe/value, one per issued window, in order.
REQ-011 cikis_gecerli_o, cikis_pixel_o[7:0], cikis_hazir_i  output/output/input  result stream, valid/ready handshake.
REQ-012 cikis_son_o  output  1  marks the final pixel of the frame.
REQ-013 mesgul_o, bitti_o  output  1 each  frame in progress; one-cycle completion pulse.

Function
REQ-014 SHALL implement states BOSTA, DOLDUR, AKIS, BOSALT; BOSTA->DOLDUR on baslat_i; baslat_i outside BOSTA is ignored.
REQ-015 DOLDUR SHALL accept 2 columns unconditionally (sutun_hazir_o=1) into the window register, then go to AKIS.
REQ-016 In AKIS each accepted column SHALL shift the 3-column window and issue one window: medyan_etkin_o high in the next cycle for exactly one cycle.
REQ-017 A credit counter SHALL equal windows issued but unreturned plus FIFO occupancy; sutun_hazir_o in AKIS SHALL be 1 only when in-flight < 10 and credit < FIFO_DERINLIK.
REQ-018 After genislik_i-2 windows in a strip, the next strip SHALL restart in DOLDUR; after yukseklik_i strips go to BOSALT.
REQ-019 BOSALT SHALL hold sutun_hazir_o=0 until credit reaches 0, then pulse bitti_o and return to BOSTA.
REQ-020 Each medyan_etkin_i SHALL push medyan_pixel_i into the FIFO; credit decrements on FIFO pop, in-flight on medyan_etkin_i.
REQ-021 cikis_gecerli_o SHALL be FIFO non-empty; data appears the cycle after push (no bypass); a pop occurs when cikis_gecerli_o and cikis_hazir_i.
REQ-022 Simultaneous push and pop SHALL keep occupancy unchanged; push when full SHALL be impossible by construction of REQ-017.
REQ-023 cikis_son_o SHALL be high with the pixel number yukseklik_i*(genislik_i-2), counted in BOSALT-aware frame order.
REQ-024 medyan_etkin_i while in BOSTA SHALL be discarded without changing any counter.
REQ-025 mesgul_o SHALL be high in every state except BOSTA.

Reset
REQ-026 rstn_i low SHALL immediately force BOSTA, empty FIFO, zero credit/in-flight/strip/column counters and window register.
REQ-027 During reset all outputs SHALL be 0; reset mid-frame SHALL abandon the frame with no bitti_o pulse.

Configuration
REQ-028 With PLANLAYICI_DURMA_SAYACI_EN defined, output durma_sayisi_o[15:0] SHALL count cycles with sutun_gecerli_i=1, sutun_hazir_o=0 in AKIS, saturating at 16'hFFFF, cleared on baslat_i and reset.
REQ-029 Without PLANLAYICI_DURMA_SAYACI_EN the port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-030 W=3,H=1, columns {01,02,03},{04,05,06},{07,08,09}, median returns 05 after 4 cycles -> one medyan_etkin_o with bytes 01..09 in order, cikis_pixel_o=05 with cikis_son_o=1, then bitti_o.
REQ-031 W=16,H=2, cikis_hazir_i=0, continuous columns -> sutun_hazir_o drops once 10 windows are in flight; with immediate medians, at credit 16; no FIFO overflow; 28 pixels total after release.
REQ-032 Same as 031 with cikis_hazir_i toggling every cycle -> output order matches input order, exactly 28 outputs, last flagged.
REQ-033 rstn_i low mid-strip with 5 in flight -> all outputs 0 asynchronously, no bitti_o; new baslat_i runs a clean W=4,H=1 frame producing 2 pixels.
REQ-034 baslat_i asserted during AKIS -> ignored, frame sizes unchanged; stray medyan_etkin_i in BOSTA -> no cikis_gecerli_o.
REQ-035 With PLANLAYICI_DURMA_SAYACI_EN, 20 stalled cycles in scenario 031 -> durma_sayisi_o=20; reaches FFFF and holds under prolonged stall.
